// File: rtl/bridge_gen.sv
// rtl/bridge_gen.sv - CPU-to-peripheral bridge: window decode, IDLE/ACC/RESP handshake, interrupt controller
// Optional bus-error reporting (pr_err, sticky IP[7]/IM[7]) is enabled by defining BRIDGE_BUSERR_EN.
module bridge_gen #(
    parameter int                 NDEV      = 6,
    parameter logic [NDEV*32-1:0] DEV_BASE  = {32'h0000_7F80, 32'h0000_7F40, 32'h0000_7F28,
                                               32'h0000_7F24, 32'h0000_7F20, 32'h0000_7F00},
    parameter logic [NDEV*32-1:0] DEV_MASK  = {32'hFFFF_FFE0, 32'hFFFF_FFE0, 32'hFFFF_FFFC,
                                               32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFF0},
    parameter int                 NIRQ      = 6,
    parameter logic [31:0]        CTRL_BASE = 32'h0000_7F60
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pr_req,
    input  logic                 pr_we,
    input  logic [29:0]          pr_addr,
    input  logic [31:0]          pr_wd,
    output logic [31:0]          pr_rd,
    output logic                 pr_ready,
    output logic                 pr_err,
    output logic [NDEV-1:0]      dev_sel,
    output logic                 dev_we,
    output logic [2:0]           dev_addr,
    output logic [31:0]          dev_wd,
    input  logic [NDEV*32-1:0]   dev_rd,
    input  logic [NIRQ-1:0]      irq_in,
    output logic [5:0]           HWInt
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [NDEV-1:0]   dev_sel_q, dev_sel_d;
    logic              dev_we_q, dev_we_d;
    logic [2:0]        dev_addr_q, dev_addr_d;
    logic [31:0]       dev_wd_q, dev_wd_d;
    logic              ctrl_q, ctrl_d;
    logic              pr_ready_q, pr_ready_d;
    logic [31:0]       pr_rd_q, pr_rd_d;
    logic [NIRQ-1:0]   irq_prev_q, irq_prev_d;
    logic [NIRQ-1:0]   im_q, im_d;
    logic [NIRQ-1:0]   ip_q, ip_d;
    logic [5:0]        hwint_q, hwint_d;
`ifdef BRIDGE_BUSERR_EN
    logic              pr_err_q, pr_err_d;
    logic              err_q, err_d;
    logic              im7_q, im7_d;
`endif

    logic [31:0]       full_addr;
    logic [NDEV-1:0]   hit;
    logic              ctrl_hit;
    logic [31:0]       dev_rdata;
    logic [31:0]       reg_rdata;
    logic              ctrl_wr;
    logic              unmapped;
    logic [NIRQ-1:0]   rise;
    logic [NIRQ-1:0]   ip_clr;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        full_addr = {pr_addr, 2'b00};
        hit       = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if ((full_addr & DEV_MASK[i*32 +: 32]) == DEV_BASE[i*32 +: 32]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
        ctrl_hit = ((full_addr & 32'hFFFF_FFF0) == CTRL_BASE);
        if (ctrl_hit) begin
            hit = '0;
        end
    end

    always_comb begin
        dev_rdata = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (dev_sel_q[i]) begin
                dev_rdata = dev_rdata | dev_rd[i*32 +: 32];
            end
        end
        reg_rdata = '0;
        case (dev_addr_q[1:0])
            2'd0: begin
                for (int i = 0; i < NIRQ; i++) reg_rdata[i] = im_q[i];
`ifdef BRIDGE_BUSERR_EN
                reg_rdata[7] = im7_q;
`endif
            end
            2'd1: begin
                for (int i = 0; i < NIRQ; i++) reg_rdata[i] = ip_q[i];
`ifdef BRIDGE_BUSERR_EN
                reg_rdata[7] = err_q;
`endif
            end
            2'd2: begin
                for (int i = 0; i < NIRQ; i++) reg_rdata[i] = irq_prev_q[i];
            end
            default: reg_rdata = '0;
        endcase
    end

    // Register writes land in the strobe cycle, same as a device write would.
    always_comb begin
        ctrl_wr    = (state_q == S_ACC) && ctrl_q && dev_we_q;
        unmapped   = (state_q == S_ACC) && !ctrl_q && (dev_sel_q == '0);
        rise       = irq_in & ~irq_prev_q;
        irq_prev_d = irq_in;
        im_d       = im_q;
        ip_clr     = '0;
        if (ctrl_wr && dev_addr_q[1:0] == 2'd0) begin
            im_d = dev_wd_q[NIRQ-1:0];
        end
        if (ctrl_wr && dev_addr_q[1:0] == 2'd1) begin
            ip_clr = dev_wd_q[NIRQ-1:0];
        end
        ip_d    = (ip_q & ~ip_clr) | rise;
        hwint_d = '0;
        for (int i = 0; i < NIRQ; i++) begin
            hwint_d[i] = ip_q[i] & im_q[i];
        end
`ifdef BRIDGE_BUSERR_EN
        im7_d = im7_q;
        if (ctrl_wr && dev_addr_q[1:0] == 2'd0) begin
            im7_d = dev_wd_q[7];
        end
        err_d = err_q;
        if (ctrl_wr && dev_addr_q[1:0] == 2'd1 && dev_wd_q[7]) begin
            err_d = 1'b0;
        end
        if (unmapped) begin
            err_d = 1'b1;
        end
        hwint_d[5] = hwint_d[5] | (err_q & im7_q);
`endif
    end

    always_comb begin
        state_d    = state_q;
        dev_sel_d  = '0;
        dev_we_d   = 1'b0;
        dev_addr_d = dev_addr_q;
        dev_wd_d   = dev_wd_q;
        ctrl_d     = ctrl_q;
        pr_ready_d = 1'b0;
        pr_rd_d    = pr_rd_q;
`ifdef BRIDGE_BUSERR_EN
        pr_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pr_req) begin
                    dev_sel_d  = hit;
                    dev_we_d   = pr_we;
                    dev_addr_d = pr_addr[2:0];
                    dev_wd_d   = pr_wd;
                    ctrl_d     = ctrl_hit;
                    state_d    = S_ACC;
                end
            end
            S_ACC: begin
                pr_ready_d = 1'b1;
                pr_rd_d    = ctrl_q ? reg_rdata : dev_rdata;
`ifdef BRIDGE_BUSERR_EN
                pr_err_d   = unmapped;
`endif
                state_d    = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dev_sel_q  <= '0;
            dev_we_q   <= 1'b0;
            dev_addr_q <= '0;
            dev_wd_q   <= '0;
            ctrl_q     <= 1'b0;
            pr_ready_q <= 1'b0;
            pr_rd_q    <= '0;
            irq_prev_q <= '0;
            im_q       <= '0;
            ip_q       <= '0;
            hwint_q    <= '0;
`ifdef BRIDGE_BUSERR_EN
            pr_err_q   <= 1'b0;
            err_q      <= 1'b0;
            im7_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dev_sel_q  <= dev_sel_d;
            dev_we_q   <= dev_we_d;
            dev_addr_q <= dev_addr_d;
            dev_wd_q   <= dev_wd_d;
            ctrl_q     <= ctrl_d;
            pr_ready_q <= pr_ready_d;
            pr_rd_q    <= pr_rd_d;
            irq_prev_q <= irq_prev_d;
            im_q       <= im_d;
            ip_q       <= ip_d;
            hwint_q    <= hwint_d;
`ifdef BRIDGE_BUSERR_EN
            pr_err_q   <= pr_err_d;
            err_q      <= err_d;
            im7_q      <= im7_d;
`endif
        end
    end

    assign pr_rd    = pr_rd_q;
    assign pr_ready = pr_ready_q;
    assign dev_sel  = dev_sel_q;
    assign dev_we   = dev_we_q;
    assign dev_addr = dev_addr_q;
    assign dev_wd   = dev_wd_q;
    assign HWInt    = hwint_q;
`ifdef BRIDGE_BUSERR_EN
    assign pr_err   = pr_err_q;
`else
    assign pr_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bridge_gen.sv
// tb/tb_bridge_gen.sv - directed + randomized bench for bridge_gen against a behavioural model
module tb_bridge_gen;

`ifdef BRIDGE_BUSERR_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pr_req;
    logic         pr_we;
    logic [29:0]  pr_addr;
    logic [31:0]  pr_wd;
    logic [31:0]  pr_rd;
    logic         pr_ready;
    logic         pr_err;
    logic [5:0]   dev_sel;
    logic         dev_we;
    logic [2:0]   dev_addr;
    logic [31:0]  dev_wd;
    logic [191:0] dev_rd;
    logic [5:0]   irq_in;
    logic [5:0]   HWInt;

    bridge_gen dut (
        .clk(clk), .rst_n(rst_n), .pr_req(pr_req), .pr_we(pr_we), .pr_addr(pr_addr),
        .pr_wd(pr_wd), .pr_rd(pr_rd), .pr_ready(pr_ready), .pr_err(pr_err),
        .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wd(dev_wd),
        .dev_rd(dev_rd), .irq_in(irq_in), .HWInt(HWInt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] win_base [6] = '{32'h7F00, 32'h7F20, 32'h7F24, 32'h7F28, 32'h7F40, 32'h7F80};
    logic [31:0] win_mask [6] = '{32'hFFFFFFF0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC,
                                  32'hFFFFFFE0, 32'hFFFFFFE0};
    logic [31:0] addr_pool [18] = '{32'h7F00, 32'h7F04, 32'h7F0C, 32'h7F20, 32'h7F24, 32'h7F28,
                                    32'h7F2C, 32'h7F30, 32'h7F40, 32'h7F5C, 32'h7F60, 32'h7F64,
                                    32'h7F68, 32'h7F6C, 32'h7F80, 32'h7F9C, 32'h7FA0, 32'h0000};

    logic [5:0]  m_im, m_ip, m_prev, m_hw;
    logic        m_err, m_im7;
    logic        wr_pending, err_pending;
    logic [1:0]  wr_off;
    logic [31:0] wr_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [5:0] rise;
        logic [5:0] clr;
        @(posedge clk);
        if (!rst_n) begin
            m_im = '0; m_ip = '0; m_prev = '0; m_hw = '0; m_err = 1'b0; m_im7 = 1'b0;
        end else begin
            m_hw = m_ip & m_im;
            if (EN && m_err && m_im7) m_hw[5] = 1'b1;
            rise = irq_in & ~m_prev;
            clr  = '0;
            if (wr_pending && wr_off == 2'd0) begin
                m_im = wr_data[5:0];
                if (EN) m_im7 = wr_data[7];
            end
            if (wr_pending && wr_off == 2'd1) begin
                clr = wr_data[5:0];
                if (EN && wr_data[7]) m_err = 1'b0;
            end
            if (EN && err_pending) m_err = 1'b1;
            m_ip   = (m_ip & ~clr) | rise;
            m_prev = irq_in;
        end
        wr_pending  = 1'b0;
        err_pending = 1'b0;
        @(negedge clk);
        chk("hwint", 32'(HWInt), 32'(m_hw));
    endtask

    task automatic access(input bit we, input logic [31:0] baddr, input logic [31:0] wd,
                          input logic [5:0] irq_acc, input string tag, output logic [31:0] rd_obs);
        logic [5:0]  exp_sel;
        logic [31:0] exp_rd;
        bit          ctrl;
        bit          unm;
        ctrl    = ((baddr & 32'hFFFFFFF0) == 32'h7F60);
        exp_sel = '0;
        if (!ctrl) begin
            for (int i = 0; i < 6; i++) begin
                if ((baddr & win_mask[i]) == win_base[i]) begin
                    exp_sel[i] = 1'b1;
                    break;
                end
            end
        end
        unm     = !ctrl && (exp_sel == '0);
        pr_req  = 1'b1;
        pr_we   = we;
        pr_addr = baddr[31:2];
        pr_wd   = wd;
        tick();
        chk({tag, ".sel"},   32'(dev_sel),  32'(exp_sel));
        chk({tag, ".we"},    32'(dev_we),   32'(we));
        chk({tag, ".addr"},  32'(dev_addr), 32'(baddr[4:2]));
        chk({tag, ".wd"},    dev_wd,        wd);
        chk({tag, ".early"}, 32'(pr_ready), 32'd0);
        exp_rd = '0;
        if (ctrl) begin
            case (baddr[3:2])
                2'd0:    exp_rd = 32'(m_im) | (32'(m_im7) << 7);
                2'd1:    exp_rd = 32'(m_ip) | (32'(m_err) << 7);
                2'd2:    exp_rd = 32'(m_prev);
                default: exp_rd = '0;
            endcase
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (exp_sel[i]) exp_rd = dev_rd[i*32 +: 32];
            end
        end
        if (ctrl && we) begin
            wr_pending = 1'b1;
            wr_off     = baddr[3:2];
            wr_data    = wd;
        end
        err_pending = unm;
        irq_in      = irq_acc;
        tick();
        chk({tag, ".ready"},  32'(pr_ready), 32'd1);
        chk({tag, ".sel_off"}, 32'(dev_sel), 32'd0);
        chk({tag, ".rd"},     pr_rd,         exp_rd);
        chk({tag, ".err"},    32'(pr_err),   32'(EN && unm));
        rd_obs = pr_rd;
        pr_req = 1'b0;
        tick();
        chk({tag, ".ready_off"}, 32'(pr_ready), 32'd0);
    endtask

    logic [31:0] rdv;
    logic [31:0] ra;

    initial begin
        rst_n = 1'b0; pr_req = 1'b0; pr_we = 1'b0; pr_addr = '0; pr_wd = '0;
        dev_rd = '0; irq_in = '0;
        wr_pending = 1'b0; err_pending = 1'b0; wr_off = '0; wr_data = '0;
        m_im = '0; m_ip = '0; m_prev = '0; m_hw = '0; m_err = 1'b0; m_im7 = 1'b0;
        tick();
        tick();
        chk("rst.ready", 32'(pr_ready), 32'd0);
        chk("rst.err",   32'(pr_err),   32'd0);
        chk("rst.rd",    pr_rd,         32'd0);
        chk("rst.sel",   32'(dev_sel),  32'd0);
        chk("rst.we",    32'(dev_we),   32'd0);
        chk("rst.addr",  32'(dev_addr), 32'd0);
        chk("rst.wd",    dev_wd,        32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) dev_rd[i*32 +: 32] = $urandom();
        dev_rd[31:0] = 32'hDEADBEEF;
        access(1'b0, 32'h7F04, 32'h0, irq_in, "rd7f04", rdv);
        chk("rd7f04.data", rdv, 32'hDEADBEEF);
        access(1'b1, 32'h7F24, 32'h5A, irq_in, "wr7f24", rdv);
        access(1'b0, 32'h7F30, 32'h0, irq_in, "unmapped", rdv);

        access(1'b1, 32'h7F60, 32'h3, irq_in, "wr_im", rdv);
        irq_in = 6'b000010;
        tick();
        irq_in = 6'b000000;
        tick();
        tick();
        chk("irq.hwint", 32'(HWInt), 32'h2);
        access(1'b0, 32'h7F64, 32'h0, irq_in, "rd_ip", rdv);
        chk("irq.ip", rdv, 32'h2);
        access(1'b1, 32'h7F64, 32'h2, irq_in, "clr_ip", rdv);
        tick();
        chk("irq.hwint_clr", 32'(HWInt), 32'h0);

        irq_in = 6'b000001;
        tick();
        irq_in = 6'b000000;
        tick();
        access(1'b1, 32'h7F64, 32'h1, 6'b000001, "setwins_clr", rdv);
        irq_in = 6'b000000;
        access(1'b0, 32'h7F64, 32'h0, irq_in, "setwins_rd", rdv);
        chk("setwins.ip0", 32'(rdv[0]), 32'd1);

        pr_req = 1'b1; pr_we = 1'b0; pr_addr = 30'(32'h7F20 >> 2);
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst.ready", 32'(pr_ready), 32'd0);
        chk("midrst.sel",   32'(dev_sel),  32'd0);
        rst_n = 1'b1; pr_req = 1'b0;
        tick();
        chk("midrst.ready2", 32'(pr_ready), 32'd0);
        tick();
        access(1'b0, 32'h7F60, 32'h0, irq_in, "midrst_im", rdv);
        chk("midrst.im", rdv, 32'd0);
        access(1'b0, 32'h7F64, 32'h0, irq_in, "midrst_ip", rdv);
        chk("midrst.ip", rdv, 32'd0);

        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < 6; i++) dev_rd[i*32 +: 32] = $urandom();
            irq_in = 6'($urandom_range(0, 63));
            ra = addr_pool[$urandom_range(0, 17)];
            access(1'($urandom_range(0, 1)), ra, $urandom(), 6'($urandom_range(0, 63)), "rand", rdv);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
